// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: hazard/branch controls in, instruction memory port, and the ID-stage slot.
// The fetch unit is the slave end; the surrounding pipeline (or a bench) is the master.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  stall;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  halt;
    logic [ADDR_WIDTH-1:0] imem_address;
    logic [31:0]           imem_data;
    logic [31:0]           id_instr;
    logic [ADDR_WIDTH-1:0] id_pc;
    logic                  id_valid;
    logic [CNT_WIDTH-1:0]  fetch_count;

    modport master (
        output stall, redirect, redirect_pc, halt, imem_data,
        input  imem_address, id_instr, id_pc, id_valid, fetch_count
    );

    modport slave (
        input  stall, redirect, redirect_pc, halt, imem_data,
        output imem_address, id_instr, id_pc, id_valid, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// MUSA IF stage: owns the PC, drives a 1-cycle-latency instruction memory and hands
// {instr, pc, valid} to ID, with stall, redirect/squash, sticky halt and a retired-fetch counter.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(1),
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  req_valid_q, req_valid_d;
    logic [CNT_WIDTH-1:0]  fetch_count_q, fetch_count_d;

    logic                  id_valid;
    logic [ADDR_WIDTH-1:0] imem_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            req_valid_q   <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            req_valid_q   <= req_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // In RUN the priority is redirect > halt > stall > advance; a redirect squashes the
    // word currently on id_* simply by not counting it and replacing req_pc.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        req_valid_d   = req_valid_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            BOOT: begin
                req_pc_d    = pc_q;
                req_valid_d = 1'b1;
                pc_d        = pc_q + PC_STEP;
                state_d     = RUN;
            end
            RUN: begin
                if (bus.redirect) begin
                    req_pc_d    = bus.redirect_pc;
                    req_valid_d = 1'b1;
                    pc_d        = bus.redirect_pc + PC_STEP;
                end else if (bus.halt) begin
                    state_d     = HALTED;
                    req_valid_d = 1'b0;
                end else if (!bus.stall) begin
                    req_pc_d    = pc_q;
                    req_valid_d = 1'b1;
                    pc_d        = pc_q + PC_STEP;
                    if (id_valid) begin
                        fetch_count_d = fetch_count_q + CNT_WIDTH'(1);
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Holding cycles re-read req_pc so the synchronous memory keeps returning the same word.
    always_comb begin
        id_valid  = req_valid_q && (state_q == RUN);
        imem_addr = req_pc_q;
        case (state_q)
            BOOT: begin
                imem_addr = pc_q;
            end
            RUN: begin
                if (bus.redirect) begin
                    imem_addr = bus.redirect_pc;
                end else if (bus.halt || bus.stall) begin
                    imem_addr = req_pc_q;
                end else begin
                    imem_addr = pc_q;
                end
            end
            default: begin
                imem_addr = req_pc_q;
            end
        endcase
    end

    assign bus.imem_address = imem_addr;
    assign bus.id_instr     = bus.imem_data;
    assign bus.id_pc        = req_pc_q;
    assign bus.id_valid     = id_valid;
    assign bus.fetch_count  = fetch_count_q;

    halted_is_sticky: assert property (
        @(posedge clock) disable iff (reset) (state_q == HALTED) |=> (state_q == HALTED));

    halt_drops_valid: assert property (
        @(posedge clock) disable iff (reset)
        (state_q == RUN && bus.halt && !bus.redirect) |=> !id_valid);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (RESET_PC 0 and 0xFFFFFFFE) share directed and random
// control stimulus and are compared each cycle against a slot/stream model of the IF stage.
module tb_fetch_unit;

    logic        clock;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic        halt;
    logic [31:0] redirect_pc;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    fetch_unit_if #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) bus0 ();
    fetch_unit_if #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) bus1 ();

    fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000), .PC_STEP(32'd1), .CNT_WIDTH(32)) dut0 (
        .clock (clock),
        .reset (rst),
        .bus   (bus0)
    );

    fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFE), .PC_STEP(32'd1), .CNT_WIDTH(32)) dut1 (
        .clock (clock),
        .reset (rst),
        .bus   (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign bus0.stall       = stall;
    assign bus0.redirect    = redirect;
    assign bus0.redirect_pc = redirect_pc;
    assign bus0.halt        = halt;
    assign bus1.stall       = stall;
    assign bus1.redirect    = redirect;
    assign bus1.redirect_pc = redirect_pc;
    assign bus1.halt        = halt;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    function automatic logic [31:0] resetPc(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFE;
    endfunction

    // Synchronous instruction memories with one cycle of read latency.
    always @(posedge clock) begin
        bus0.imem_data <= memWord(bus0.imem_address);
        bus1.imem_data <= memWord(bus1.imem_address);
    end

    logic [31:0] o_addr  [2];
    logic [31:0] o_pc    [2];
    logic [31:0] o_instr [2];
    logic [31:0] o_cnt   [2];
    logic        o_valid [2];

    assign o_addr[0]  = bus0.imem_address;
    assign o_addr[1]  = bus1.imem_address;
    assign o_pc[0]    = bus0.id_pc;
    assign o_pc[1]    = bus1.id_pc;
    assign o_instr[0] = bus0.id_instr;
    assign o_instr[1] = bus1.id_instr;
    assign o_cnt[0]   = bus0.fetch_count;
    assign o_cnt[1]   = bus1.fetch_count;
    assign o_valid[0] = bus0.id_valid;
    assign o_valid[1] = bus1.id_valid;

    // Model: mode 0 = booting, 1 = delivering, 2 = halted; slot_pc is the word shown to ID,
    // next_pc the next sequential word to fetch, count the instructions ID has taken.
    int          m_mode    [2];
    logic [31:0] m_slot_pc [2];
    logic [31:0] m_next_pc [2];
    logic [31:0] m_count   [2];

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mode[i]    = 0;
                m_slot_pc[i] = resetPc(i);
                m_next_pc[i] = resetPc(i);
                m_count[i]   = 32'd0;
            end else if (m_mode[i] == 0) begin
                m_slot_pc[i] = m_next_pc[i];
                m_next_pc[i] = m_next_pc[i] + 32'd1;
                m_mode[i]    = 1;
            end else if (m_mode[i] == 1) begin
                if (redirect) begin
                    m_slot_pc[i] = redirect_pc;
                    m_next_pc[i] = redirect_pc + 32'd1;
                end else if (halt) begin
                    m_mode[i] = 2;
                end else if (!stall) begin
                    m_count[i]   = m_count[i] + 32'd1;
                    m_slot_pc[i] = m_next_pc[i];
                    m_next_pc[i] = m_next_pc[i] + 32'd1;
                end
            end
        end
        if (rst) check_en = 1'b1;
    end

    function automatic logic [31:0] expectedAddr(input int i);
        if (m_mode[i] == 0) return m_next_pc[i];
        if (m_mode[i] == 2) return m_slot_pc[i];
        if (redirect) return redirect_pc;
        if (halt || stall) return m_slot_pc[i];
        return m_next_pc[i];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic compareModel();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("dut%0d id_valid", i), {31'd0, o_valid[i]}, {31'd0, (m_mode[i] == 1)});
            checkOutput($sformatf("dut%0d id_pc", i), o_pc[i], m_slot_pc[i]);
            checkOutput($sformatf("dut%0d imem_address", i), o_addr[i], expectedAddr(i));
            checkOutput($sformatf("dut%0d fetch_count", i), o_cnt[i], m_count[i]);
            if (m_mode[i] == 1) begin
                checkOutput($sformatf("dut%0d id_instr", i), o_instr[i], memWord(m_slot_pc[i]));
            end
        end
    endtask

    always @(negedge clock) begin
        #2;
        if (check_en) compareModel();
    end

    task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                 input logic h, input logic [31:0] rpc);
        @(negedge clock);
        rst         = r;
        stall       = s;
        redirect    = rd;
        halt        = h;
        redirect_pc = rpc;
        #3;
    endtask

    initial begin
        int r;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        halt        = 1'b0;
        redirect_pc = 32'd0;
        @(posedge clock);

        // Boot cycle, then free run.
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("lit boot id_valid", {31'd0, bus0.id_valid}, 32'd0);
        checkOutput("lit boot id_pc", bus0.id_pc, 32'h0);
        checkOutput("lit boot imem_address", bus0.imem_address, 32'h0);
        checkOutput("lit boot fetch_count", bus0.fetch_count, 32'd0);
        checkOutput("lit wrap boot imem_address", bus1.imem_address, 32'hFFFF_FFFE);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("lit first id_valid", {31'd0, bus0.id_valid}, 32'd1);
        checkOutput("lit first id_pc", bus0.id_pc, 32'h0);
        checkOutput("lit first imem_address", bus0.imem_address, 32'h1);
        checkOutput("lit first id_instr", bus0.id_instr, memWord(32'h0));
        checkOutput("lit wrap pc0", bus1.id_pc, 32'hFFFF_FFFE);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("lit run id_pc 1", bus0.id_pc, 32'h1);
        checkOutput("lit wrap pc1", bus1.id_pc, 32'hFFFF_FFFF);

        // Three stall cycles while id_pc is 2.
        applyStimulus(0, 1, 0, 0, 32'h0);
        checkOutput("lit stall id_pc", bus0.id_pc, 32'h2);
        checkOutput("lit stall imem_address", bus0.imem_address, 32'h2);
        checkOutput("lit wrap pc2", bus1.id_pc, 32'h0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 1, 0, 0, 32'h0);
            checkOutput("lit stall held id_pc", bus0.id_pc, 32'h2);
            checkOutput("lit stall held id_instr", bus0.id_instr, memWord(32'h2));
            checkOutput("lit stall held imem_address", bus0.imem_address, 32'h2);
            checkOutput("lit stall held fetch_count", bus0.fetch_count, 32'd2);
        end
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("lit release id_pc", bus0.id_pc, 32'h2);
        checkOutput("lit release imem_address", bus0.imem_address, 32'h3);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("lit after stall id_pc", bus0.id_pc, 32'h3);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("lit id_pc 4", bus0.id_pc, 32'h4);
        checkOutput("lit four accepted", bus0.fetch_count, 32'd4);

        // Redirect to 0x10 while id_pc is 5, then redirect+stall to 0x20.
        applyStimulus(0, 0, 1, 0, 32'h10);
        checkOutput("lit pre redirect id_pc", bus0.id_pc, 32'h5);
        checkOutput("lit redirect imem_address", bus0.imem_address, 32'h10);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("lit redirect target id_pc", bus0.id_pc, 32'h10);
        checkOutput("lit redirect target valid", {31'd0, bus0.id_valid}, 32'd1);
        checkOutput("lit redirect target instr", bus0.id_instr, memWord(32'h10));
        checkOutput("lit squashed not counted", bus0.fetch_count, 32'd5);
        applyStimulus(0, 1, 1, 0, 32'h20);
        checkOutput("lit redirect next id_pc", bus0.id_pc, 32'h11);
        checkOutput("lit redirect+stall imem_address", bus0.imem_address, 32'h20);

        // Halt, then redirect/stall while halted must be ignored.
        applyStimulus(0, 0, 0, 1, 32'h0);
        checkOutput("lit redirect+stall id_pc", bus0.id_pc, 32'h20);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("lit halted id_valid", {31'd0, bus0.id_valid}, 32'd0);
        checkOutput("lit halted imem_address", bus0.imem_address, 32'h20);
        checkOutput("lit halted fetch_count", bus0.fetch_count, 32'd6);
        applyStimulus(0, 1, 1, 0, 32'h40);
        checkOutput("lit halted ignores redirect valid", {31'd0, bus0.id_valid}, 32'd0);
        checkOutput("lit halted ignores redirect address", bus0.imem_address, 32'h20);
        applyStimulus(1, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("lit rebooted id_pc", bus0.id_pc, 32'h0);
        checkOutput("lit rebooted fetch_count", bus0.fetch_count, 32'd0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("lit rebooted first valid", {31'd0, bus0.id_valid}, 32'd1);

        // Randomized control traffic, including redirects near the address wrap.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rpc;
            r = $urandom_range(0, 2);
            if (r == 0)      rpc = $urandom;
            else if (r == 1) rpc = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else             rpc = 32'($urandom_range(0, 255));
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 10,
                          $urandom_range(0, 199) == 0,
                          rpc);
        end
        applyStimulus(0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
